// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell codes, board type, bot FSM states and the line table.
package ttt_pkg;

    localparam int unsigned N_CELLS = 9;
    localparam int unsigned N_LINES = 8;
    localparam int unsigned IDX_W   = 4;

    typedef logic [1:0] cell_t;
    typedef cell_t [N_CELLS-1:0] board_t;

    localparam cell_t EMPTY = 2'b00;
    localparam cell_t P1    = 2'b01;
    localparam cell_t P2    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_NEXT,
        S_WAIT,
        S_SEL,
        S_ACK,
        S_ABORT
    } state_e;

    // Rows, then columns, then diagonals.
    localparam logic [IDX_W-1:0] LINES [N_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic cell_t opponent(input cell_t mark);
        return (mark == P1) ? P2 : P1;
    endfunction

    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_CELLS-1:0] mask);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int n = int'(N_CELLS) - 1; n >= 0; n--) begin
            if (mask[n]) idx = IDX_W'(n);
        end
        return idx;
    endfunction

endpackage

// File: rtl/move_chooser.sv
// Combinational move policy: win, block, center, corners, edges; lowest cell index within a rule.
module move_chooser
    import ttt_pkg::*;
(
    input  board_t           board_i,
    input  cell_t            mark_i,
    output logic [IDX_W-1:0] target_o,
    output logic             valid_o
);

    localparam logic [N_CELLS-1:0] CORNER_MASK = 9'b101000101;
    localparam logic [N_CELLS-1:0] EDGE_MASK   = 9'b010101010;

    cell_t                opp_mark;
    logic [N_CELLS-1:0]   win_mask;
    logic [N_CELLS-1:0]   blk_mask;
    logic [N_CELLS-1:0]   empty_mask;
    logic [1:0]           n_bot;
    logic [1:0]           n_opp;
    logic [1:0]           n_emp;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     hole;

    assign opp_mark = opponent(mark_i);

    // A line with two equal marks and one hole flags that hole as a win or block cell.
    always_comb begin
        win_mask = '0;
        blk_mask = '0;
        n_bot    = '0;
        n_opp    = '0;
        n_emp    = '0;
        idx      = '0;
        hole     = '0;
        for (int l = 0; l < int'(N_LINES); l++) begin
            n_bot = '0;
            n_opp = '0;
            n_emp = '0;
            hole  = '0;
            for (int k = 0; k < 3; k++) begin
                idx = LINES[l][k];
                if (board_i[idx] == mark_i) begin
                    n_bot = n_bot + 2'd1;
                end else if (board_i[idx] == opp_mark) begin
                    n_opp = n_opp + 2'd1;
                end else if (board_i[idx] == EMPTY) begin
                    n_emp = n_emp + 2'd1;
                    hole  = idx;
                end
            end
            if (n_bot == 2'd2 && n_emp == 2'd1) win_mask[hole] = 1'b1;
            if (n_opp == 2'd2 && n_emp == 2'd1) blk_mask[hole] = 1'b1;
        end
    end

    always_comb begin
        for (int n = 0; n < int'(N_CELLS); n++) begin
            empty_mask[n] = (board_i[n] == EMPTY);
        end
    end

    always_comb begin
        target_o = '0;
        valid_o  = |empty_mask;
        if (|win_mask) begin
            target_o = lowest_set(win_mask);
        end else if (|blk_mask) begin
            target_o = lowest_set(blk_mask);
        end else if (empty_mask[4]) begin
            target_o = IDX_W'(4);
        end else if (|(empty_mask & CORNER_MASK)) begin
            target_o = lowest_set(empty_mask & CORNER_MASK);
        end else begin
            target_o = lowest_set(empty_mask & EDGE_MASK);
        end
    end

endmodule

// File: rtl/auto_player.sv
// Automatic tic-tac-toe opponent: picks a cell, walks the cursor there with next pulses, commits with sel.
module auto_player
    import ttt_pkg::*;
#(
    parameter logic        BOT_ID    = 1'b1,
    parameter int unsigned PULSE_GAP = 4,
    parameter int unsigned ACK_WAIT  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       player,
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] c,
    input  logic [1:0] d,
    input  logic [1:0] e,
    input  logic [1:0] f,
    input  logic [1:0] g,
    input  logic [1:0] h,
    input  logic [1:0] i,
    input  logic [1:0] winner,
    input  logic [3:0] position,
    output logic       next,
    output logic       sel,
    output logic       busy,
    output logic [3:0] target,
    output logic       fault
);

    localparam int unsigned GAP_W  = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
    localparam int unsigned ACK_W  = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;
    localparam int unsigned STEP_W = 4;
    localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(9);
    localparam cell_t BOT_MARK = BOT_ID ? P2 : P1;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  target_q, target_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [ACK_W-1:0]  ack_q, ack_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              fault_q, fault_d;
    logic              next_q, next_d;
    logic              sel_q, sel_d;
    logic              busy_q, busy_d;

    board_t           board;
    logic [IDX_W-1:0] pick;
    logic             pick_valid;
    logic             my_turn;
    logic             game_live;
    logic             trigger;
    logic             abort_c;

    assign board     = {i, h, g, f, e, d, c, b, a};
    assign my_turn   = (player == BOT_ID);
    assign game_live = (winner == 2'b00);
    assign trigger   = enable && my_turn && game_live && pick_valid;
    assign abort_c   = !enable || !game_live || !my_turn || (board[target_q] != EMPTY);

    move_chooser u_chooser (
        .board_i  (board),
        .mark_i   (BOT_MARK),
        .target_o (pick),
        .valid_o  (pick_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            gap_q    <= '0;
            ack_q    <= '0;
            step_q   <= '0;
            fault_q  <= 1'b0;
            next_q   <= 1'b0;
            sel_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            gap_q    <= gap_d;
            ack_q    <= ack_d;
            step_q   <= step_d;
            fault_q  <= fault_d;
            next_q   <= next_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
        end
    end

    // Pulse and busy registers are decoded from the upcoming state so they line up with it.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        gap_d    = gap_q;
        ack_d    = ack_q;
        step_d   = step_q;
        fault_d  = fault_q;
        unique case (state_q)
            S_IDLE: begin
                gap_d  = '0;
                ack_d  = '0;
                step_d = '0;
                if (trigger) begin
                    target_d = pick;
                    state_d  = S_STEP;
                end
            end
            S_STEP: begin
                if (abort_c) begin
                    state_d = S_ABORT;
                end else if (position == target_q) begin
                    state_d = S_SEL;
                end else if (step_q == STEP_LIMIT) begin
                    fault_d = 1'b1;
                    state_d = S_ABORT;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                step_d  = step_q + STEP_W'(1);
                gap_d   = '0;
                state_d = abort_c ? S_ABORT : S_WAIT;
            end
            S_WAIT: begin
                if (abort_c) begin
                    state_d = S_ABORT;
                end else if (gap_q == GAP_W'(PULSE_GAP - 1)) begin
                    gap_d   = '0;
                    state_d = S_STEP;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_SEL: begin
                ack_d   = '0;
                state_d = S_ACK;
            end
            S_ACK: begin
                if (!my_turn || !game_live) begin
                    state_d = S_IDLE;
                end else if (ack_q == ACK_W'(ACK_WAIT - 1)) begin
                    fault_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ack_d = ack_q + ACK_W'(1);
                end
            end
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        next_d = (state_d == S_NEXT);
        sel_d  = (state_d == S_SEL);
        busy_d = (state_d != S_IDLE);
    end

    assign next   = next_q;
    assign sel    = sel_q;
    assign busy   = busy_q;
    assign target = target_q;
    assign fault  = fault_q;

endmodule

// File: tb/tb_auto_player.sv
// Bench for auto_player: a small game model answers the pulses, a timeline model predicts every output.
module tb_auto_player;

    localparam int PERIOD = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       player;
    logic [1:0] bd [9];
    logic [1:0] winner;
    logic [3:0] position;
    logic       nxt;
    logic       sel;
    logic       busy;
    logic [3:0] target;
    logic       fault;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit chk_en, p_on, fault_base, game_ack;
    int p_t0, p_d, p_tgt, p_cut, p_busy_end, p_fault_rel, prev_tgt;
    int n_next_seen, sel_rel;

    int   r;
    logic e_next, e_sel, e_busy, e_fault;
    int   e_tgt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    auto_player #(.BOT_ID(1'b1), .PULSE_GAP(4), .ACK_WAIT(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .player(player),
        .a(bd[0]), .b(bd[1]), .c(bd[2]), .d(bd[3]), .e(bd[4]),
        .f(bd[5]), .g(bd[6]), .h(bd[7]), .i(bd[8]),
        .winner(winner), .position(position),
        .next(nxt), .sel(sel), .busy(busy), .target(target), .fault(fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit wins(input logic [1:0] bb [9], input logic [1:0] m);
        for (int k = 0; k < 3; k++) begin
            if (bb[3*k] == m && bb[3*k+1] == m && bb[3*k+2] == m) return 1'b1;
            if (bb[k] == m && bb[k+3] == m && bb[k+6] == m) return 1'b1;
        end
        if (bb[0] == m && bb[4] == m && bb[8] == m) return 1'b1;
        if (bb[2] == m && bb[4] == m && bb[6] == m) return 1'b1;
        return 1'b0;
    endfunction

    // Policy as "which empty cell would finish a line", then fixed preference lists.
    function automatic int model_target(input logic [1:0] bb [9], input logic [1:0] me);
        logic [1:0] t [9];
        logic [1:0] opp;
        int corners [4] = '{0, 2, 6, 8};
        int edges   [4] = '{1, 3, 5, 7};
        opp = (me == 2'b10) ? 2'b01 : 2'b10;
        for (int n = 0; n < 9; n++)
            if (bb[n] == 2'b00) begin t = bb; t[n] = me; if (wins(t, me)) return n; end
        for (int n = 0; n < 9; n++)
            if (bb[n] == 2'b00) begin t = bb; t[n] = opp; if (wins(t, opp)) return n; end
        if (bb[4] == 2'b00) return 4;
        for (int n = 0; n < 4; n++) if (bb[corners[n]] == 2'b00) return corners[n];
        for (int n = 0; n < 4; n++) if (bb[edges[n]] == 2'b00) return edges[n];
        return -1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            r       = cyc - p_t0;
            e_next  = p_on && r >= 2 && r <= p_cut && ((r - 2) % PERIOD == 0) && ((r - 2) / PERIOD < p_d);
            e_sel   = p_on && r == 2 + PERIOD * p_d && r <= p_cut;
            e_busy  = p_on && r >= 1 && r <= p_busy_end;
            e_tgt   = (p_on && r >= 1) ? p_tgt : prev_tgt;
            e_fault = fault_base || (p_on && p_fault_rel >= 0 && r >= p_fault_rel);
            check("next", 32'(nxt), 32'(e_next));
            check("sel", 32'(sel), 32'(e_sel));
            check("busy", 32'(busy), 32'(e_busy));
            check("target", 32'(target), e_tgt);
            check("fault", 32'(fault), 32'(e_fault));
            if (sel === 1'b1 && p_on) check("sel_position", 32'(position), p_tgt);
        end
    end

    // One clock of the game: cursor advances on next, mark placed and turn passed on sel.
    task automatic cycle();
        logic nx, sl;
        @(negedge clk);
        nx = nxt;
        sl = sel;
        if (nx) n_next_seen++;
        if (sl) sel_rel = cyc - p_t0;
        @(posedge clk);
        #1;
        if (sl && game_ack) begin
            bd[position] = 2'b10;
            player = ~player;
        end
        if (nx) position = (position == 4'd8) ? 4'd0 : position + 4'd1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic load(input logic [17:0] v);
        for (int n = 0; n < 9; n++) bd[n] = v[2*n +: 2];
    endtask

    task automatic start_plan();
        if (p_on) prev_tgt = p_tgt;
        p_tgt       = model_target(bd, 2'b10);
        p_d         = (p_tgt - int'(position) + 9) % 9;
        p_t0        = cyc;
        p_cut       = 100000;
        p_busy_end  = 3 + PERIOD * p_d;
        p_fault_rel = -1;
        n_next_seen = 0;
        sel_rel     = -1;
        p_on        = 1'b1;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; player = 1'b0; winner = 2'b00; position = 4'd0;
        for (int n = 0; n < 9; n++) bd[n] = 2'b00;
        chk_en = 1'b0; p_on = 1'b0; fault_base = 1'b0; game_ack = 1'b1;
        prev_tgt = 0; p_tgt = 0; p_t0 = 0; p_d = 0; p_cut = 0; p_busy_end = 0; p_fault_rel = -1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_next", 32'(nxt), 0);
        check("reset_sel", 32'(sel), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_target", 32'(target), 0);
        check("reset_fault", 32'(fault), 0);
        rst = 1'b1;
        chk_en = 1'b1;
        run(3);

        // Empty board from cell 0: center, four steps.
        load(18'd0); position = 4'd0; player = 1'b1; enable = 1'b1;
        start_plan();
        check("model_empty_center", p_tgt, 4);
        run(p_busy_end + 3);
        check("s1_target", 32'(target), 4);
        check("s1_next_count", n_next_seen, 4);
        check("s1_sel_cycle", sel_rel, 26);
        check("s1_mark_placed", 32'(bd[4]), 32'h2);

        // Winning cell beats blocking cell; already on target.
        load({2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10});
        position = 4'd2; player = 1'b1;
        start_plan();
        check("model_win_first", p_tgt, 2);
        run(p_busy_end + 3);
        check("s2_next_count", n_next_seen, 0);
        check("s2_sel_cycle", sel_rel, 2);

        // Block the opponent row.
        load({2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00});
        position = 4'd0; player = 1'b1;
        start_plan();
        check("model_block", p_tgt, 5);
        run(p_busy_end + 3);
        check("s3_target", 32'(target), 5);

        // Cursor wrap 7 -> 8 -> 0 -> 1 -> 2.
        load({2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10});
        position = 4'd7; player = 1'b1;
        start_plan();
        run(p_busy_end + 3);
        check("s4_next_count", n_next_seen, 4);
        check("s4_sel_cycle", sel_rel, 26);
        check("s4_final_position", 32'(position), 2);

        // Game ends while waiting between pulses.
        load(18'd0); position = 4'd0; player = 1'b1; enable = 1'b1;
        start_plan();
        run(4);
        winner = 2'b01;
        p_cut = 4; p_busy_end = 5;
        run(10);
        check("s5_next_count", n_next_seen, 1);
        check("s5_fault", 32'(fault), 0);
        winner = 2'b00; enable = 1'b0;
        run(2);

        // Target cell taken mid-walk.
        load(18'd0); position = 4'd0; player = 1'b1; enable = 1'b1;
        start_plan();
        run(10);
        bd[4] = 2'b01;
        p_cut = 10; p_busy_end = 11;
        run(1);
        enable = 1'b0;
        run(8);
        check("s6_next_count", n_next_seen, 2);

        // Turn never passes after sel: fault after the ack window.
        load(18'd0); position = 4'd4; player = 1'b1; enable = 1'b1; game_ack = 1'b0;
        start_plan();
        p_busy_end = 18; p_fault_rel = 19;
        run(5);
        enable = 1'b0;
        run(20);
        check("s7_fault", 32'(fault), 1);
        fault_base = 1'b1;
        game_ack = 1'b1;
        player = 1'b0;
        run(2);

        // Reset while a next pulse is high.
        load(18'd0); position = 4'd0; player = 1'b1; enable = 1'b1;
        start_plan();
        run(8);
        check("s8_next_before_reset", 32'(nxt), 1);
        chk_en = 1'b0;
        rst = 1'b0;
        #1;
        check("s8_next_reset", 32'(nxt), 0);
        check("s8_sel_reset", 32'(sel), 0);
        check("s8_busy_reset", 32'(busy), 0);
        check("s8_target_reset", 32'(target), 0);
        check("s8_fault_reset", 32'(fault), 0);
        enable = 1'b0; player = 1'b0;
        p_on = 1'b0; prev_tgt = 0; fault_base = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk_en = 1'b1;
        run(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
